// File: rtl/dcache_fsm_pkg.sv
// Shared definitions for the L1 data-cache control FSM: state encoding,
// default geometry and the memory address that receives the hit counter.
package dcache_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WB        = 3'd1,
    FILL      = 3'd2,
    FLUSH_CHK = 3'd3,
    FLUSH_WB  = 3'd4,
    CTSTORE   = 3'd5,
    HALT      = 3'd6
  } dcache_state_t;

  localparam int DEF_WORDS  = 2;
  localparam int DEF_FRAMES = 16;
  localparam int DEF_CNTW   = 32;

  // Word address the datapath uses while cnt_store is high.
  localparam logic [31:0] HITCNT_ADDR = 32'h0000_3100;

endpackage

// File: rtl/dcache_fsm_if.sv
// Signal bundle between the cache control FSM and the dcache datapath /
// memory arbiter.
//
// Handshake: dREN/dWEN are level requests held for the whole transfer; a word
// moves in every cycle where dwait is low, and nothing moves while dwait is
// high. blk_wr, clean and fill_done are single-cycle strobes that only fire
// in cycles where a word actually completes.
interface dcache_fsm_if
  import dcache_fsm_pkg::*;
#(
  parameter int WORDS  = DEF_WORDS,
  parameter int FRAMES = DEF_FRAMES,
  parameter int CNTW   = DEF_CNTW
);
  localparam int WOW = $clog2(WORDS);
  localparam int FIW = $clog2(FRAMES);

  // core / datapath side
  logic            dmemREN;
  logic            dmemWEN;
  logic            dhit;
  logic            dirty;
  logic            dwait;
  logic            flush;
  logic            frame_dirty;
  // fsm side
  logic            dREN;
  logic            dWEN;
  logic [WOW-1:0]  word_off;
  logic            blk_wr;
  logic            fill_done;
  logic            clean;
  logic [FIW-1:0]  flush_idx;
  logic            flushing;
  logic            cnt_store;
  logic [CNTW-1:0] hitcnt;
  logic            halt;
  dcache_state_t   state_dbg;

  modport master (
    input  dmemREN, dmemWEN, dhit, dirty, dwait, flush, frame_dirty,
    output dREN, dWEN, word_off, blk_wr, fill_done, clean, flush_idx,
           flushing, cnt_store, hitcnt, halt, state_dbg
  );

  modport slave (
    output dmemREN, dmemWEN, dhit, dirty, dwait, flush, frame_dirty,
    input  dREN, dWEN, word_off, blk_wr, fill_done, clean, flush_idx,
           flushing, cnt_store, hitcnt, halt, state_dbg
  );

endinterface

// File: rtl/dcache_fsm_hitcnt.sv
// Wrapping up/down hit counter. up and dn are never both high in normal use;
// if they are, the value holds.
module dcache_hitcnt #(
  parameter int CNTW = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            up,
  input  logic            dn,
  output logic [CNTW-1:0] value
);

  // count hits up, misses down, modulo 2^CNTW
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      value <= '0;
    end else if (up && !dn) begin
      value <= value + CNTW'(1);
    end else if (dn && !up) begin
      value <= value - CNTW'(1);
    end
  end

endmodule

// File: rtl/dcache_fsm.sv
// L1 data-cache control FSM: dirty-victim writeback and block fill on a miss,
// full-cache flush walk on halt followed by a store of the hit counter.
module dcache_fsm
  import dcache_fsm_pkg::*;
#(
  parameter int WORDS  = DEF_WORDS,
  parameter int FRAMES = DEF_FRAMES,
  parameter int CNTW   = DEF_CNTW
) (
  input  logic          CLK,
  input  logic          RST,
  dcache_fsm_if.master  bus
);

  localparam int WOW = $clog2(WORDS);
  localparam int FIW = $clog2(FRAMES);
  localparam logic [WOW-1:0] LAST_WORD  = WOW'(WORDS - 1);
  localparam logic [FIW-1:0] LAST_FRAME = FIW'(FRAMES - 1);

  dcache_state_t  state, next_state;
  logic [WOW-1:0] word_off_q, word_off_n;
  logic [FIW-1:0] flush_idx_q, flush_idx_n;
  logic           dren_q, dwen_q, flushing_q, cnt_store_q, halt_q;
  logic           blk_wr, clean, fill_done;
  logic           cnt_up, cnt_dn;
  logic           req;

  assign req = bus.dmemREN | bus.dmemWEN;

  // state, counters and Moore outputs; outputs are computed from next_state
  // so they are registered yet line up with the state they belong to
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      word_off_q  <= '0;
      flush_idx_q <= '0;
      dren_q      <= 1'b0;
      dwen_q      <= 1'b0;
      flushing_q  <= 1'b0;
      cnt_store_q <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state       <= next_state;
      word_off_q  <= word_off_n;
      flush_idx_q <= flush_idx_n;
      dren_q      <= (next_state == FILL);
      dwen_q      <= (next_state == WB) || (next_state == FLUSH_WB) ||
                     (next_state == CTSTORE);
      flushing_q  <= (next_state == FLUSH_CHK) || (next_state == FLUSH_WB);
      cnt_store_q <= (next_state == CTSTORE);
      halt_q      <= (next_state == HALT);
    end
  end

  // next-state, counter updates and completion strobes
  always_comb begin
    next_state  = state;
    word_off_n  = word_off_q;
    flush_idx_n = flush_idx_q;
    blk_wr      = 1'b0;
    clean       = 1'b0;
    fill_done   = 1'b0;
    cnt_up      = 1'b0;
    cnt_dn      = 1'b0;
    unique case (state)
      IDLE: begin
        // a miss wins over a pending flush; a hit is counted even when the
        // flush walk starts in the same cycle
        if (req && !bus.dhit) begin
          cnt_dn     = 1'b1;
          next_state = bus.dirty ? WB : FILL;
        end else begin
          cnt_up = req;
          if (bus.flush) next_state = FLUSH_CHK;
        end
      end
      WB, FLUSH_WB: begin
        if (!bus.dwait) begin
          if (word_off_q == LAST_WORD) begin
            clean      = 1'b1;
            word_off_n = '0;
            if (state == WB) begin
              next_state = FILL;
            end else if (flush_idx_q == LAST_FRAME) begin
              next_state = CTSTORE;
            end else begin
              flush_idx_n = flush_idx_q + FIW'(1);
              next_state  = FLUSH_CHK;
            end
          end else begin
            word_off_n = word_off_q + WOW'(1);
          end
        end
      end
      FILL: begin
        blk_wr = !bus.dwait;
        if (!bus.dwait) begin
          if (word_off_q == LAST_WORD) begin
            fill_done  = 1'b1;
            word_off_n = '0;
            next_state = IDLE;
          end else begin
            word_off_n = word_off_q + WOW'(1);
          end
        end
      end
      FLUSH_CHK: begin
        // flush_idx parks at the last frame; only reset clears it
        if (bus.frame_dirty) begin
          next_state = FLUSH_WB;
        end else if (flush_idx_q == LAST_FRAME) begin
          next_state = CTSTORE;
        end else begin
          flush_idx_n = flush_idx_q + FIW'(1);
        end
      end
      CTSTORE: begin
        if (!bus.dwait) next_state = HALT;
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  dcache_hitcnt #(.CNTW(CNTW)) u_hitcnt (
    .CLK   (CLK),
    .RST   (RST),
    .up    (cnt_up),
    .dn    (cnt_dn),
    .value (bus.hitcnt)
  );

  assign bus.dREN      = dren_q;
  assign bus.dWEN      = dwen_q;
  assign bus.word_off  = word_off_q;
  assign bus.blk_wr    = blk_wr;
  assign bus.clean     = clean;
  assign bus.fill_done = fill_done;
  assign bus.flush_idx = flush_idx_q;
  assign bus.flushing  = flushing_q;
  assign bus.cnt_store = cnt_store_q;
  assign bus.halt      = halt_q;
  assign bus.state_dbg = state;

endmodule
